pipe_hazard_ctrl: RTL and testbench

// Interlock and flush controller for the 5-stage pipeline (IF/ID/EX/MEM/WB), no forwarding.

---
 rtl/pipe_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : RAW interlock, taken-branch flush and post-reset warm-up control
//            for a 5-stage non-forwarding pipeline.
// Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int WARMUP = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      ir_d,
    input  logic             d_valid,
    input  logic             br_taken_e,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             redirect,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [0:0] {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    localparam logic [3:0]       c_WARM_LAST = 4'(WARMUP - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX   = '1;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_wcnt;

    logic       r_sbe_v;
    logic [4:0] r_sbe_rd;
    logic       r_sbm_v;
    logic [4:0] r_sbm_rd;

    logic [5:0] w_op;
    logic [4:0] w_rd;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic       w_is_rr;
    logic       w_is_ld;
    logic       w_is_st;
    logic       w_writes;
    logic       w_hazard;
    logic       w_issued;
    logic       w_flush_evt;
    logic       w_stall_evt;
    logic       w_unused_bits;

    assign w_op          = ir_d[31:26];
    assign w_rd          = ir_d[25:21];
    assign w_rs1         = ir_d[20:16];
    assign w_rs2         = ir_d[15:11];
    assign w_unused_bits = ^ir_d[10:0];

    assign w_is_rr  = (w_op[5:3] == 3'b000);
    assign w_is_ld  = (w_op == 6'b001001);
    assign w_is_st  = (w_op == 6'b001000);
    assign w_writes = (w_is_rr | w_is_ld) & (w_rd != 5'd0);

    // A source register is busy if an older writer in EX or MEM targets it.
    function automatic logic f_busy(input logic [4:0] r,
                                    input logic ev, input logic [4:0] erd,
                                    input logic mv, input logic [4:0] mrd);
        return (r != 5'd0) && ((ev && (erd == r)) || (mv && (mrd == r)));
    endfunction

    assign w_hazard = d_valid & (r_state == ST_RUN) &
        (  f_busy(w_rs1, r_sbe_v, r_sbe_rd, r_sbm_v, r_sbm_rd)
        | (w_is_rr & f_busy(w_rs2, r_sbe_v, r_sbe_rd, r_sbm_v, r_sbm_rd))
        | (w_is_st & f_busy(w_rd,  r_sbe_v, r_sbe_rd, r_sbm_v, r_sbm_rd)));

    always_comb begin
        w_state_nxt = r_state;
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        redirect    = 1'b0;
        w_flush_evt = 1'b0;
        w_stall_evt = 1'b0;
        if (reset || (r_state == ST_WARMUP)) begin
            pc_hold     = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            if (r_wcnt == c_WARM_LAST) begin
                w_state_nxt = ST_RUN;
            end
        end else if (br_taken_e) begin
            // Branch wins over a stall: the stalled instruction is wrong-path anyway.
            redirect    = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            w_flush_evt = 1'b1;
        end else if (w_hazard) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
            w_stall_evt = 1'b1;
        end
    end

    assign w_issued = (r_state == ST_RUN) & d_valid & ~idex_bubble;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_WARMUP;
            r_wcnt    <= 4'd0;
            r_sbe_v   <= 1'b0;
            r_sbe_rd  <= 5'd0;
            r_sbm_v   <= 1'b0;
            r_sbm_rd  <= 5'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            if (r_state == ST_WARMUP) begin
                r_wcnt <= r_wcnt + 4'd1;
            end
            r_sbm_v  <= r_sbe_v;
            r_sbm_rd <= r_sbe_rd;
            r_sbe_v  <= w_issued & w_writes;
            r_sbe_rd <= w_rd;
            if (w_stall_evt && (stall_cnt != c_CNT_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (w_flush_evt && (flush_cnt != c_CNT_MAX)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed and randomized self-checking bench for pipe_hazard_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int WARMUP = 2;
    localparam int CNT_W  = 4;
    localparam int CMAX   = 15;

    localparam logic [31:0] LW3  = 32'h24600000;  // load r3
    localparam logic [31:0] ADD5 = 32'h00A32000;  // r5 <- r3,r4
    localparam logic [31:0] ADD3 = 32'h00611000;  // r3 <- r1,r2
    localparam logic [31:0] OTH1 = 32'h40010000;  // non-writer reading r1
    localparam logic [31:0] SW3  = 32'h20600000;  // store of r3
    localparam logic [31:0] ADD0 = 32'h00011000;  // r0 <- r1,r2
    localparam logic [31:0] ADD6 = 32'h00C00000;  // r6 <- r0,r0

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [31:0]      ir_d = 32'h0;
    logic             d_valid = 1'b0;
    logic             br_taken_e = 1'b0;
    logic             pc_hold, ifid_hold, ifid_flush, idex_bubble, redirect;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(.WARMUP(WARMUP), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .ir_d(ir_d), .d_valid(d_valid),
        .br_taken_e(br_taken_e), .pc_hold(pc_hold), .ifid_hold(ifid_hold),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .redirect(redirect),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // Reference model: cycles of warm-up left, destination register of the
    // instruction in EX and in MEM (0 = none), and unbounded event counts.
    typedef struct {
        bit ph, ih, ifl, bub, red, issued;
        int dest;
    } exp_t;

    bit m_init  = 0;
    int m_warm  = 0;
    int m_ex    = 0;
    int m_mem   = 0;
    int m_stall = 0;
    int m_flush = 0;
    exp_t cur;

    function automatic exp_t model(input bit rst, input logic [31:0] ir, input bit dv,
                                   input bit br, input int warm, input int ex, input int mem);
        exp_t e;
        bit [31:0] reads, busy;
        bit rr, ld, st;
        e = '{default: 0};
        rr = (ir[31:29] == 3'b000);
        ld = (ir[31:26] == 6'b001001);
        st = (ir[31:26] == 6'b001000);
        reads = 32'h0;
        reads[ir[20:16]] = 1'b1;
        if (rr) reads[ir[15:11]] = 1'b1;
        if (st) reads[ir[25:21]] = 1'b1;
        reads[0] = 1'b0;
        busy = 32'h0;
        busy[ex] = 1'b1;
        busy[mem] = 1'b1;
        busy[0] = 1'b0;
        e.dest = (rr || ld) ? int'(ir[25:21]) : 0;
        if (rst || warm > 0) begin
            e.ph = 1; e.ifl = 1; e.bub = 1;
        end else if (br) begin
            e.red = 1; e.ifl = 1; e.bub = 1;
        end else if (dv && ((reads & busy) != 0)) begin
            e.ph = 1; e.ih = 1; e.bub = 1;
        end
        e.issued = !rst && warm == 0 && dv && !e.bub;
        return e;
    endfunction

    always_comb cur = model(reset, ir_d, d_valid, br_taken_e, m_warm, m_ex, m_mem);

    always @(posedge clk) begin
        if (reset) begin
            m_init  <= 1;
            m_warm  <= WARMUP;
            m_ex    <= 0;
            m_mem   <= 0;
            m_stall <= 0;
            m_flush <= 0;
        end else if (m_init) begin
            if (m_warm > 0) m_warm <= m_warm - 1;
            m_mem <= m_ex;
            m_ex  <= cur.issued ? cur.dest : 0;
            if (cur.red) m_flush <= m_flush + 1;
            if (cur.ih)  m_stall <= m_stall + 1;
        end
    end

    // Single compare process against the model, every cycle after first reset.
    always @(negedge clk) begin
        if (m_init) begin
            check("m_pc_hold",     32'(pc_hold),     32'(cur.ph));
            check("m_ifid_hold",   32'(ifid_hold),   32'(cur.ih));
            check("m_ifid_flush",  32'(ifid_flush),  32'(cur.ifl));
            check("m_idex_bubble", 32'(idex_bubble), 32'(cur.bub));
            check("m_redirect",    32'(redirect),    32'(cur.red));
            check("m_stall_cnt",   32'(stall_cnt),   32'((m_stall > CMAX) ? CMAX : m_stall));
            check("m_flush_cnt",   32'(flush_cnt),   32'((m_flush > CMAX) ? CMAX : m_flush));
            check("m_hold_xor_flush", 32'(ifid_hold & ifid_flush), 32'h0);
        end
    end

    task automatic drive(input bit rst, input logic [31:0] ir, input bit dv, input bit br);
        @(posedge clk);
        #1;
        reset = rst; ir_d = ir; d_valid = dv; br_taken_e = br;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_ir();
        logic [5:0] op;
        case ($urandom % 4)
            0: op = {3'b000, 3'($urandom)};
            1: op = 6'b001001;
            2: op = 6'b001000;
            default: op = {1'b1, 5'($urandom)};
        endcase
        return {op, 5'($urandom % 4), 5'($urandom % 4), 5'($urandom % 4), 11'($urandom)};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and warm-up window
        drive(1, 32'h0, 0, 0); sample();
        check("rst_pc_hold", 32'(pc_hold), 32'd1);
        check("rst_ifid_flush", 32'(ifid_flush), 32'd1);
        check("rst_idex_bubble", 32'(idex_bubble), 32'd1);
        check("rst_ifid_hold", 32'(ifid_hold), 32'd0);
        check("rst_redirect", 32'(redirect), 32'd0);
        drive(0, 32'h0, 0, 0); sample();
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        check("warm1_pc_hold", 32'(pc_hold), 32'd1);
        check("warm1_ifid_flush", 32'(ifid_flush), 32'd1);
        drive(0, 32'h0, 0, 0); sample();
        check("warm2_pc_hold", 32'(pc_hold), 32'd1);
        check("warm2_ifid_flush", 32'(ifid_flush), 32'd1);
        drive(0, 32'h0, 0, 0); sample();
        check("run_pc_hold", 32'(pc_hold), 32'd0);
        check("run_ifid_flush", 32'(ifid_flush), 32'd0);

        // Load in EX -> two stall cycles for dependent ADD
        drive(0, LW3, 1, 0); sample();
        check("lw_issue", 32'(idex_bubble), 32'd0);
        drive(0, ADD5, 1, 0); sample();
        check("raw_ex_bubble", 32'(idex_bubble), 32'd1);
        check("raw_ex_hold", 32'(ifid_hold), 32'd1);
        drive(0, ADD5, 1, 0); sample();
        check("raw_mem_bubble", 32'(idex_bubble), 32'd1);
        drive(0, ADD5, 1, 0); sample();
        check("raw_release", 32'(idex_bubble), 32'd0);
        check("raw_stall_cnt", 32'(stall_cnt), 32'd2);

        // Producer in MEM -> one stall, store data register counted as a read
        drive(0, 32'h0, 0, 0); drive(0, 32'h0, 0, 0);
        drive(0, ADD3, 1, 0); sample();
        check("add3_issue", 32'(idex_bubble), 32'd0);
        drive(0, OTH1, 1, 0); sample();
        check("oth_issue", 32'(idex_bubble), 32'd0);
        drive(0, SW3, 1, 0); sample();
        check("sw_stall", 32'(idex_bubble), 32'd1);
        drive(0, SW3, 1, 0); sample();
        check("sw_release", 32'(idex_bubble), 32'd0);
        check("sw_stall_cnt", 32'(stall_cnt), 32'd3);

        // r0 never creates a dependency
        drive(0, 32'h0, 0, 0); drive(0, 32'h0, 0, 0);
        drive(0, ADD0, 1, 0);
        drive(0, ADD6, 1, 0); sample();
        check("r0_no_stall", 32'(idex_bubble), 32'd0);
        check("r0_stall_cnt", 32'(stall_cnt), 32'd3);

        // Branch and hazard together: flush only
        drive(0, 32'h0, 0, 0); drive(0, 32'h0, 0, 0);
        drive(0, LW3, 1, 0);
        drive(0, ADD5, 1, 1); sample();
        check("brhz_redirect", 32'(redirect), 32'd1);
        check("brhz_ifid_flush", 32'(ifid_flush), 32'd1);
        check("brhz_ifid_hold", 32'(ifid_hold), 32'd0);
        check("brhz_pc_hold", 32'(pc_hold), 32'd0);
        drive(0, 32'h0, 0, 0); sample();
        check("brhz_flush_cnt", 32'(flush_cnt), 32'd1);
        check("brhz_stall_cnt", 32'(stall_cnt), 32'd3);

        // Flush counter saturation, then reset in the middle of a stall
        repeat (20) drive(0, 32'h0, 0, 1);
        drive(0, 32'h0, 0, 0); sample();
        check("flush_sat", 32'(flush_cnt), 32'hF);
        drive(0, LW3, 1, 0);
        drive(0, ADD5, 1, 0); sample();
        check("pre_rst_stall", 32'(idex_bubble), 32'd1);
        drive(1, ADD5, 1, 0); sample();
        check("midrst_pc_hold", 32'(pc_hold), 32'd1);
        check("midrst_ifid_hold", 32'(ifid_hold), 32'd0);
        drive(0, ADD5, 1, 0); sample();
        check("midrst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("midrst_flush_cnt", 32'(flush_cnt), 32'd0);
        check("midrst_warm", 32'(ifid_flush), 32'd1);
        drive(0, ADD5, 1, 0);
        drive(0, ADD5, 1, 0); sample();
        check("midrst_sb_clear", 32'(idex_bubble), 32'd0);

        // Randomized traffic against the model
        repeat (2000) begin
            drive(($urandom % 100) == 0, rand_ir(), ($urandom % 4) != 0, ($urandom % 8) == 0);
        end
        drive(0, 32'h0, 0, 0);
        drive(0, 32'h0, 0, 0); sample();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
